// File: rtl/pkt_loopback_port_if.sv
// Flit handshake bundle between a DMA endpoint (master) and the loopback port (slave).
// The DMA side drives rx/data_i and credit_i; the port side drives credit_o, tx and data_o.
interface pkt_loopback_port_if #(
  parameter int FLIT_WIDTH = 32
);
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_o;
  logic                  credit_i;

  modport master (output rx, data_i, credit_i, input credit_o, tx, data_o);
  modport slave  (input rx, data_i, credit_i, output credit_o, tx, data_o);
endinterface

// File: rtl/pkt_loopback_port.sv
// Store-and-forward loopback endpoint: buffers whole packets in a flit FIFO and replays
// each one with its header replaced by ECHO_HEADER. Oversize packets are consumed and dropped.
module pkt_loopback_port #(
  parameter int                    FLIT_WIDTH   = 32,
  parameter int                    BUFFER_DEPTH = 16,
  parameter logic [FLIT_WIDTH-1:0] ECHO_HEADER  = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  pkt_loopback_port_if.slave              port,
  output logic [$clog2(BUFFER_DEPTH):0]   buffer_level,
  output logic [15:0]                     pkt_in_count,
  output logic [15:0]                     pkt_out_count,
  output logic [15:0]                     drop_count
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [FLIT_WIDTH-1:0] MAX_SIZE = FLIT_WIDTH'(BUFFER_DEPTH - 2);
  localparam logic [FLIT_WIDTH-1:0] ONE      = FLIT_WIDTH'(1);
  localparam logic [LW-1:0]         FULL     = LW'(BUFFER_DEPTH);

  typedef enum logic [1:0] {IN_HEADER, IN_SIZE, IN_PAYLOAD, IN_DISCARD} in_state_t;
  typedef enum logic [1:0] {EG_IDLE, EG_HEADER, EG_SIZE, EG_PAYLOAD}    eg_state_t;

  in_state_t in_state, in_next;
  eg_state_t eg_state, eg_next;

  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [LW-1:0]         level, pkt_ready;
  logic [FLIT_WIDTH-1:0] remaining, out_remaining;
  logic [FLIT_WIDTH-1:0] head;

  logic accept, wr_en, rollback, drop, tail_in, rem_load, rem_dec;
  logic pop, tail_out, orem_load, orem_dec;
  logic tx;
  logic [FLIT_WIDTH-1:0] data_o;

  assign head         = mem[rptr];
  assign buffer_level = level;

  // Discarded flits never touch the FIFO, so a full buffer must not stall a discard.
  assign port.credit_o = reset && ((in_state == IN_DISCARD) || (level < FULL));
  assign accept        = port.rx && port.credit_o;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    in_next  = in_state;
    wr_en    = 1'b0;
    rollback = 1'b0;
    drop     = 1'b0;
    tail_in  = 1'b0;
    rem_load = 1'b0;
    rem_dec  = 1'b0;
    case (in_state)
      IN_HEADER: if (accept) begin
        wr_en   = 1'b1;
        in_next = IN_SIZE;
      end
      IN_SIZE: if (accept) begin
        if (port.data_i > MAX_SIZE) begin
          // Oversize sizes are always non-zero, so a discard phase always follows.
          rollback = 1'b1;
          drop     = 1'b1;
          rem_load = 1'b1;
          in_next  = IN_DISCARD;
        end else begin
          wr_en = 1'b1;
          if (port.data_i == '0) begin
            tail_in = 1'b1;
            in_next = IN_HEADER;
          end else begin
            rem_load = 1'b1;
            in_next  = IN_PAYLOAD;
          end
        end
      end
      IN_PAYLOAD: if (accept) begin
        wr_en   = 1'b1;
        rem_dec = 1'b1;
        if (remaining == ONE) begin
          tail_in = 1'b1;
          in_next = IN_HEADER;
        end
      end
      IN_DISCARD: if (accept) begin
        rem_dec = 1'b1;
        if (remaining == ONE) in_next = IN_HEADER;
      end
      default: in_next = IN_HEADER;
    endcase
  end

  always_comb begin
    eg_next   = eg_state;
    pop       = 1'b0;
    tail_out  = 1'b0;
    orem_load = 1'b0;
    orem_dec  = 1'b0;
    tx        = 1'b0;
    data_o    = ECHO_HEADER;
    case (eg_state)
      EG_IDLE: if (pkt_ready != '0) eg_next = EG_HEADER;
      EG_HEADER: begin
        tx = 1'b1;
        if (port.credit_i) begin
          pop     = 1'b1;
          eg_next = EG_SIZE;
        end
      end
      EG_SIZE: begin
        tx     = 1'b1;
        data_o = head;
        if (port.credit_i) begin
          pop = 1'b1;
          if (head == '0) begin
            tail_out = 1'b1;
            eg_next  = EG_IDLE;
          end else begin
            orem_load = 1'b1;
            eg_next   = EG_PAYLOAD;
          end
        end
      end
      EG_PAYLOAD: begin
        tx     = 1'b1;
        data_o = head;
        if (port.credit_i) begin
          pop      = 1'b1;
          orem_dec = 1'b1;
          if (out_remaining == ONE) begin
            tail_out = 1'b1;
            eg_next  = EG_IDLE;
          end
        end
      end
      default: eg_next = EG_IDLE;
    endcase
  end

  assign port.tx     = tx;
  assign port.data_o = data_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_state      <= IN_HEADER;
      eg_state      <= EG_IDLE;
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      pkt_ready     <= '0;
      remaining     <= '0;
      out_remaining <= '0;
      pkt_in_count  <= '0;
      pkt_out_count <= '0;
      drop_count    <= '0;
    end else begin
      in_state  <= in_next;
      eg_state  <= eg_next;
      if (wr_en)         wptr <= wptr + AW'(1);
      else if (rollback) wptr <= wptr - AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      level     <= level + LW'(wr_en) - LW'(pop) - LW'(rollback);
      pkt_ready <= pkt_ready + LW'(tail_in) - LW'(tail_out);
      if (rem_load)     remaining <= port.data_i;
      else if (rem_dec) remaining <= remaining - ONE;
      if (orem_load)     out_remaining <= head;
      else if (orem_dec) out_remaining <= out_remaining - ONE;
      if (tail_in)  pkt_in_count  <= pkt_in_count + 16'd1;
      if (tail_out) pkt_out_count <= pkt_out_count + 16'd1;
      if (drop)     drop_count    <= drop_count + 16'd1;
    end
  end

  // NOTE: the flit storage has no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr] <= port.data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(wr_en && level == FULL));
      assert (!(pop && level == '0));
    end
  end

endmodule

// File: tb/tb_pkt_loopback_port.sv
// Randomized bench for pkt_loopback_port: a packet-level model predicts the echoed flit
// stream and counters; a negedge monitor records what the port actually emits.
module tb_pkt_loopback_port;

  localparam int          DEPTH = 16;
  localparam logic [31:0] ECHO  = 32'hEC40_0E40;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  buffer_level;
  logic [15:0] pkt_in_count, pkt_out_count, drop_count;

  pkt_loopback_port_if #(.FLIT_WIDTH(32)) bus ();

  pkt_loopback_port #(.FLIT_WIDTH(32), .BUFFER_DEPTH(DEPTH), .ECHO_HEADER(ECHO)) dut (
    .clock        (clock),
    .reset        (reset),
    .port         (bus),
    .buffer_level (buffer_level),
    .pkt_in_count (pkt_in_count),
    .pkt_out_count(pkt_out_count),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_in   = 0;
  int          exp_drop = 0;
  int          acc_cnt  = 0;
  int          max_level = 0;
  logic [31:0] exp_q [$];
  logic [31:0] obs   [$];

  // Inputs change 1 ns after the rising edge, so negedge values are what the next edge uses.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.tx && bus.credit_i) obs.push_back(bus.data_o);
      if (bus.rx && bus.credit_o) acc_cnt++;
      if (int'(buffer_level) > max_level) max_level = int'(buffer_level);
    end
  end

  function automatic int first_diff();
    int n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs[i] !== exp_q[i]) return i;
    if (obs.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [31:0] at_or_x(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic send_flit(input logic [31:0] f);
    int n = 0;
    bus.rx     = 1'b1;
    bus.data_i = f;
    @(negedge clock);
    while (!bus.credit_o && n < 500) begin
      n++;
      @(negedge clock);
    end
    if (!bus.credit_o) begin
      n_checks++;
      $display("FAIL ingress_timeout: flit %h not accepted after %0d cycles", f, n);
    end
    @(posedge clock);
    #1;
    bus.rx = 1'b0;
  endtask

  // Payload i is base+i when base is non-zero, otherwise random.
  task automatic send_packet(input logic [31:0] hdr, input int size, input logic [31:0] base);
    logic [31:0] p [$];
    for (int i = 0; i < size; i++) p.push_back(base != 0 ? base + 32'(i) : $urandom);
    if (size > DEPTH - 2) exp_drop++;
    else begin
      exp_q.push_back(ECHO);
      exp_q.push_back(32'(size));
      foreach (p[i]) exp_q.push_back(p[i]);
      exp_in++;
    end
    send_flit(hdr);
    send_flit(32'(size));
    foreach (p[i]) send_flit(p[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    bus.credit_i = 1'b1;
    @(negedge clock);
    while ((pkt_out_count !== 16'(exp_in) || bus.tx !== 1'b0) && n < 3000) begin
      n++;
      @(negedge clock);
    end
    n_checks++;
    if (pkt_out_count !== 16'(exp_in) || bus.tx !== 1'b0)
      $display("FAIL %s_drain: pkt_out_count=%0d tx=%b want %0d and 0", name, pkt_out_count, bus.tx, 16'(exp_in));
    else n_pass++;
    @(posedge clock);
    #1;
  endtask

  task automatic check_stream(input string name);
    int d = first_diff();
    n_checks++;
    if (d >= 0)
      $display("FAIL %s_stream: flit %0d got %h want %h (got %0d flits, want %0d)",
               name, d, at_or_x(obs, d), at_or_x(exp_q, d), obs.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic check_counts(input string name);
    n_checks++;
    if (pkt_in_count !== 16'(exp_in) || pkt_out_count !== 16'(exp_in) || drop_count !== 16'(exp_drop)
        || buffer_level !== 5'd0)
      $display("FAIL %s_counts: in=%0d out=%0d drop=%0d level=%0d want in=out=%0d drop=%0d level=0",
               name, pkt_in_count, pkt_out_count, drop_count, buffer_level, exp_in, exp_drop);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.credit_o !== 1'b0 || bus.tx !== 1'b0 || bus.data_o !== ECHO)
      $display("FAIL reset_outputs: credit_o=%b tx=%b data_o=%h want 0 0 %h", bus.credit_o, bus.tx, bus.data_o, ECHO);
    else n_pass++;
    n_checks++;
    if (buffer_level !== 5'd0 || pkt_in_count !== 16'd0 || pkt_out_count !== 16'd0 || drop_count !== 16'd0)
      $display("FAIL reset_state: level=%0d in=%0d out=%0d drop=%0d want all 0",
               buffer_level, pkt_in_count, pkt_out_count, drop_count);
    else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.credit_o !== 1'b1) $display("FAIL reset_release_credit: got %b want 1", bus.credit_o);
    else n_pass++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    obs.delete(); exp_q.delete();
    bus.credit_i = 1'b1;
    send_packet(32'h0101, 3, 32'hA);
    wait_drain("basic");
    check_stream("basic");
    check_counts("basic");
  endtask

  task automatic test_size_zero();
    obs.delete(); exp_q.delete();
    bus.credit_i = 1'b0;
    exp_q.push_back(ECHO); exp_q.push_back(32'd0); exp_in++;
    send_flit(32'h22);
    @(negedge clock);
    n_checks++;
    if (bus.tx !== 1'b0) $display("FAIL zero_tx_before_tail: got %b want 0", bus.tx);
    else n_pass++;
    @(posedge clock); #1;
    send_flit(32'd0);
    @(negedge clock);
    n_checks++;
    if (bus.tx !== 1'b0) $display("FAIL zero_latency_idle: tx got %b want 0 right after tail", bus.tx);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (bus.tx !== 1'b1 || bus.data_o !== ECHO)
      $display("FAIL zero_latency_header: tx=%b data_o=%h want 1 %h", bus.tx, bus.data_o, ECHO);
    else n_pass++;
    @(posedge clock); #1;
    wait_drain("zero");
    check_stream("zero");
    check_counts("zero");
  endtask

  task automatic test_backpressure();
    bit blocked_ok = 1'b1;
    obs.delete(); exp_q.delete();
    bus.credit_i = 1'b0;
    send_packet($urandom, 6, 32'h0);
    @(negedge clock);
    n_checks++;
    if (buffer_level !== 5'd8 || bus.credit_o !== 1'b1)
      $display("FAIL bp_half: level=%0d credit_o=%b want 8 1", buffer_level, bus.credit_o);
    else n_pass++;
    @(posedge clock); #1;
    send_packet($urandom, 6, 32'h0);
    @(negedge clock);
    n_checks++;
    if (buffer_level !== 5'd16 || bus.credit_o !== 1'b0)
      $display("FAIL bp_full: level=%0d credit_o=%b want 16 0", buffer_level, bus.credit_o);
    else n_pass++;
    @(posedge clock); #1;
    fork
      send_packet($urandom, 6, 32'h0);
      begin
        repeat (4) begin
          @(negedge clock);
          if (bus.credit_o !== 1'b0) blocked_ok = 1'b0;
        end
        @(posedge clock); #1;
        bus.credit_i = 1'b1;
      end
    join
    n_checks++;
    if (!blocked_ok) $display("FAIL bp_blocked: credit_o rose while full, want 0");
    else n_pass++;
    wait_drain("bp");
    check_stream("bp");
    check_counts("bp");
  endtask

  task automatic test_oversize();
    int acc0;
    obs.delete(); exp_q.delete();
    bus.credit_i = 1'b1;
    max_level = 0;
    acc0 = acc_cnt;
    send_packet($urandom, 20, 32'h0);
    send_packet($urandom, 2, 32'h0);
    wait_drain("oversize");
    n_checks++;
    if (acc_cnt - acc0 != 26) $display("FAIL oversize_accepted: got %0d flits want 26", acc_cnt - acc0);
    else n_pass++;
    n_checks++;
    if (max_level > 4) $display("FAIL oversize_max_level: got %0d want <= 4", max_level);
    else n_pass++;
    check_stream("oversize");
    check_counts("oversize");
  endtask

  task automatic test_same_edge_tails();
    logic [15:0] in0, out0;
    logic [31:0] b_pay;
    bit stayed_idle = 1'b1;
    obs.delete(); exp_q.delete();
    bus.credit_i = 1'b0;
    send_packet($urandom, 1, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    b_pay = $urandom;
    exp_q.push_back(ECHO); exp_q.push_back(32'd1); exp_q.push_back(b_pay); exp_in++;
    bus.credit_i = 1'b1;
    send_flit($urandom);
    send_flit(32'd1);
    in0 = pkt_in_count; out0 = pkt_out_count;
    send_flit(b_pay);
    n_checks++;
    if (pkt_in_count !== in0 + 16'd1 || pkt_out_count !== out0 + 16'd1)
      $display("FAIL tails_counters: in=%0d out=%0d want %0d %0d", pkt_in_count, pkt_out_count,
               in0 + 16'd1, out0 + 16'd1);
    else n_pass++;
    wait_drain("tails");
    repeat (5) begin
      @(negedge clock);
      if (bus.tx !== 1'b0) stayed_idle = 1'b0;
    end
    n_checks++;
    if (!stayed_idle) $display("FAIL tails_idle: tx rose after both packets drained, want 0");
    else n_pass++;
    @(posedge clock); #1;
    check_stream("tails");
    check_counts("tails");
  endtask

  task automatic test_reset_mid();
    obs.delete(); exp_q.delete();
    bus.credit_i = 1'b0;
    send_flit($urandom);
    send_flit(32'd8);
    repeat (3) send_flit($urandom);
    @(negedge clock);
    n_checks++;
    if (buffer_level !== 5'd5) $display("FAIL mid_level_before: got %0d want 5", buffer_level);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.credit_o !== 1'b0 || bus.tx !== 1'b0 || buffer_level !== 5'd0 || pkt_in_count !== 16'd0)
      $display("FAIL mid_reset: credit_o=%b tx=%b level=%0d in=%0d want 0 0 0 0",
               bus.credit_o, bus.tx, buffer_level, pkt_in_count);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_in = 0; exp_drop = 0;
    obs.delete(); exp_q.delete();
    send_packet($urandom, 1, 32'h0);
    wait_drain("mid");
    check_stream("mid");
    check_counts("mid");
  endtask

  task automatic test_random();
    bit done = 1'b0;
    obs.delete(); exp_q.delete();
    fork
      begin
        for (int k = 0; k < 14; k++) send_packet($urandom, int'($urandom_range(0, 16)), 32'h0);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clock); #1;
        bus.credit_i = 1'($urandom_range(0, 1));
      end
    join
    wait_drain("random");
    check_stream("random");
    check_counts("random");
  endtask

  initial begin
    reset = 1'b0;
    bus.rx = 1'b0;
    bus.data_i = '0;
    bus.credit_i = 1'b0;
    test_reset();
    test_basic();
    test_size_zero();
    test_backpressure();
    test_oversize();
    test_same_edge_tails();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
